somador_sequencial: RTL and testbench

SOMADOR_SEQUENCIAL -- requirements
Module: somador_sequencial

---
 rtl/somador_sequencial.sv | 129 ++++++++++++
 tb/tb_somador_sequencial.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/somador_sequencial.sv
// Sequential signed adder/subtractor that processes FATIA bits per clock.
// The operands are latched at start. The sum is built chunk by chunk, from the
// least significant chunk up, in a partial register. Resultado and the flags
// update only when the last chunk is done, so they always show the most
// recent completed operation.
//
// state   | meaning
// --------+-------------------------------------------------------------
// OCIOSO  | idle, waiting for Iniciar
// CALCULO | adding one chunk per clock (Ocupado=1)
// FIM     | one-cycle completion (Pronto=1); Iniciar here restarts at once
module somador_sequencial #(
    parameter int LARGURA = 8,
    parameter int FATIA   = 2
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Iniciar,
    input  logic               Operacao,
    input  logic [LARGURA-1:0] Entrada1,
    input  logic [LARGURA-1:0] Entrada2,
    output logic [LARGURA-1:0] Resultado,
    output logic               Ocupado,
    output logic               Pronto,
    output logic               Carry,
    output logic               Overflow,
    output logic               Zero
);

    localparam int N     = LARGURA / FATIA;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULO = 2'd1,
        FIM     = 2'd2
    } estado_t;

    estado_t estado;
    estado_t proximo;

    logic [LARGURA-1:0] op_a;
    logic [LARGURA-1:0] op_b;       // already inverted for subtraction
    logic [LARGURA-1:0] parcial;
    logic [LARGURA-1:0] parcial_prox;
    logic [IDX_W-1:0]   indice;
    logic               vai_um;
    logic [FATIA-1:0]   fatia_a;
    logic [FATIA-1:0]   fatia_b;
    logic [FATIA-1:0]   soma_fatia;
    logic               carry_fatia;
    logic               ultima;
    logic               aceita;
    logic               overflow_prox;
    int                 base;

    assign ultima = (indice == IDX_W'(N - 1));
    // A start request is honoured in OCIOSO and FIM; it is ignored mid-operation.
    assign aceita = Iniciar && (estado != CALCULO);

    // State register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) estado <= OCIOSO;
        else         estado <= proximo;
    end

    // Next-state logic.
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (Iniciar) proximo = CALCULO;
            CALCULO: if (ultima)  proximo = FIM;
            FIM:     proximo = Iniciar ? CALCULO : OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Status outputs decoded directly from the state.
    always_comb begin
        Ocupado = (estado == CALCULO);
        Pronto  = (estado == FIM);
    end

    // One-chunk adder and the partial word with the current chunk merged in.
    always_comb begin
        base = int'(indice) * FATIA;
        fatia_a = op_a[base +: FATIA];
        fatia_b = op_b[base +: FATIA];
        {carry_fatia, soma_fatia} = {1'b0, fatia_a} + {1'b0, fatia_b}
                                    + {{FATIA{1'b0}}, vai_um};
        parcial_prox = parcial;
        parcial_prox[base +: FATIA] = soma_fatia;
        // Same-sign operands giving an opposite-sign sum is exactly
        // carry-into-MSB XOR carry-out-of-MSB, and needs no per-bit carry.
        overflow_prox = (op_a[LARGURA-1] == op_b[LARGURA-1]) &&
                        (soma_fatia[FATIA-1] != op_a[LARGURA-1]);
    end

    // Operand capture, chunk iteration and result/flag update.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            op_a      <= '0;
            op_b      <= '0;
            parcial   <= '0;
            indice    <= '0;
            vai_um    <= 1'b0;
            Resultado <= '0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b1;
        end else if (aceita) begin
            op_a   <= Entrada1;
            op_b   <= Operacao ? ~Entrada2 : Entrada2;
            vai_um <= Operacao;
            indice <= '0;
        end else if (estado == CALCULO) begin
            parcial <= parcial_prox;
            vai_um  <= carry_fatia;
            indice  <= indice + 1'b1;
            if (ultima) begin
                Resultado <= parcial_prox;
                Carry     <= carry_fatia;
                Overflow  <= overflow_prox;
                Zero      <= (parcial_prox == '0);
            end
        end
    end

endmodule

// File: tb/tb_somador_sequencial.sv
// Directed bench for somador_sequencial: reset state, latency, add/subtract
// corner cases, ignored restart, reset abort, and a 0..7 sweep on
// instances with FATIA = 1, 2, 4 and 8.
module tb_somador_sequencial;

    logic       clk_sys;
    logic       rst_b;
    logic [3:0] ini;
    logic       op_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] res  [4];
    logic       busy [4];
    logic       done [4];
    logic       cy   [4];
    logic       ov   [4];
    logic       zr   [4];

    int checks = 0;
    int errors = 0;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    somador_sequencial #(.LARGURA(8), .FATIA(1)) u_f1 (
        .Clock(clk_sys), .Resetn(rst_b), .Iniciar(ini[0]), .Operacao(op_in),
        .Entrada1(a_in), .Entrada2(b_in), .Resultado(res[0]), .Ocupado(busy[0]),
        .Pronto(done[0]), .Carry(cy[0]), .Overflow(ov[0]), .Zero(zr[0]));

    somador_sequencial #(.LARGURA(8), .FATIA(2)) u_f2 (
        .Clock(clk_sys), .Resetn(rst_b), .Iniciar(ini[1]), .Operacao(op_in),
        .Entrada1(a_in), .Entrada2(b_in), .Resultado(res[1]), .Ocupado(busy[1]),
        .Pronto(done[1]), .Carry(cy[1]), .Overflow(ov[1]), .Zero(zr[1]));

    somador_sequencial #(.LARGURA(8), .FATIA(4)) u_f4 (
        .Clock(clk_sys), .Resetn(rst_b), .Iniciar(ini[2]), .Operacao(op_in),
        .Entrada1(a_in), .Entrada2(b_in), .Resultado(res[2]), .Ocupado(busy[2]),
        .Pronto(done[2]), .Carry(cy[2]), .Overflow(ov[2]), .Zero(zr[2]));

    somador_sequencial #(.LARGURA(8), .FATIA(8)) u_f8 (
        .Clock(clk_sys), .Resetn(rst_b), .Iniciar(ini[3]), .Operacao(op_in),
        .Entrada1(a_in), .Entrada2(b_in), .Resultado(res[3]), .Ocupado(busy[3]),
        .Pronto(done[3]), .Carry(cy[3]), .Overflow(ov[3]), .Zero(zr[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {Resultado, Carry, Overflow, Zero} for instance k
    function automatic logic [10:0] saida(input int k);
        return {res[k], cy[k], ov[k], zr[k]};
    endfunction

    // Reference from signed/unsigned integer arithmetic.
    function automatic logic [10:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic op);
        int sa, sb, ua, ub, t;
        logic c, v;
        logic [7:0] r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        if (!op) begin
            t = sa + sb;
            c = (ua + ub) > 255;
        end else begin
            t = sa - sb;
            c = (ua >= ub);
        end
        r = 8'(t);
        v = (t > 127) || (t < -128);
        return {r, c, v, (r == 8'h00)};
    endfunction

    task automatic start(input int k, input logic [7:0] a, input logic [7:0] b, input logic op);
        a_in   = a;
        b_in   = b;
        op_in  = op;
        ini[k] = 1'b1;
        @(posedge clk_sys);
        #1 ini[k] = 1'b0;
    endtask

    // Counts falling edges until Pronto is seen (bounded).
    task automatic wait_done(input int k, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk_sys);
            cnt++;
        end while (!done[k] && cnt < 40);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic op, input logic [10:0] exp);
        int cnt;
        start(1, a, b, op);
        wait_done(1, cnt);
        chk({tag, "_lat"}, cnt, 5);
        chk(tag, saida(1), exp);
    endtask

    task automatic sweep(input int k, input int n);
        int cnt;
        logic [6:0] j;
        j = 7'd0;
        start(k, 8'(j[2:0]), 8'(j[5:3]), j[6]);
        for (int v = 0; v < 128; v++) begin
            j = 7'(v);
            wait_done(k, cnt);
            chk($sformatf("sw_f%0d_lat_%0d", k, v), cnt, n + 1);
            chk($sformatf("sw_f%0d_%0d", k, v), saida(k),
                ref_model(8'(j[2:0]), 8'(j[5:3]), j[6]));
            if (v < 127) begin
                j = 7'(v + 1);
                start(k, 8'(j[2:0]), 8'(j[5:3]), j[6]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [7:0] captured;

        rst_b = 1'b0;
        ini   = 4'b0;
        op_in = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_out_%0d", k), saida(k), {8'h00, 1'b0, 1'b0, 1'b1});
            chk($sformatf("rst_st_%0d", k), {busy[k], done[k]}, 2'b00);
        end
        rst_b = 1'b1;

        // 5+3: busy for four cycles with result held, then one Pronto cycle
        start(1, 8'd5, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            chk($sformatf("add53_calc_%0d", i), {busy[1], done[1], res[1]}, {2'b10, 8'h00});
        end
        @(negedge clk_sys);
        chk("add53_st", {busy[1], done[1]}, 2'b01);
        chk("add53_out", saida(1), {8'h08, 1'b0, 1'b0, 1'b0});
        @(negedge clk_sys);
        chk("add53_after", {busy[1], done[1]}, 2'b00);

        run_op("add_127_1", 8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0});
        run_op("add_m1_1",  8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});
        run_op("sub_3_5",   8'h03, 8'h05, 1'b1, {8'hFE, 1'b0, 1'b0, 1'b0});
        run_op("sub_5_5",   8'h05, 8'h05, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1});
        run_op("sub_m128_1", 8'h80, 8'h01, 1'b1, {8'h7F, 1'b1, 1'b1, 1'b0});
        repeat (2) @(negedge clk_sys);

        // restart attempt during CALCULO must be ignored
        start(1, 8'd10, 8'd20, 1'b0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        a_in   = 8'd1;
        b_in   = 8'd1;
        op_in  = 1'b1;
        ini[1] = 1'b1;
        @(posedge clk_sys);
        #1 ini[1] = 1'b0;
        pulses   = 0;
        captured = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (done[1]) begin
                pulses++;
                captured = res[1];
            end
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_res", captured, 8'h1E);
        chk("ign_flags", saida(1), {8'h1E, 1'b0, 1'b0, 1'b0});

        // reset during CALCULO aborts without Pronto
        start(1, 8'd7, 8'd7, 1'b0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_b = 1'b0;
        @(negedge clk_sys);
        chk("abort_out", saida(1), {8'h00, 1'b0, 1'b0, 1'b1});
        chk("abort_st", {busy[1], done[1]}, 2'b00);
        rst_b  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            if (done[1] || busy[1]) pulses++;
        end
        chk("abort_quiet", pulses, 0);
        run_op("add_2_2", 8'd2, 8'd2, 1'b0, {8'h04, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge clk_sys);

        sweep(0, 8);
        repeat (2) @(negedge clk_sys);
        sweep(1, 4);
        repeat (2) @(negedge clk_sys);
        sweep(2, 2);
        repeat (2) @(negedge clk_sys);
        sweep(3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
